sdram_responder: RTL and testbench

- Synthesizable single-chip SDR SDRAM device emulator.
- Sits on the DRAM side of sdram_ctrl and stands in for the physical chip in simulation and FPGA loopback builds.
- Decodes CS/RAS/CAS/WE commands and tracks the open row of each of 4 banks.
- Stores data in a small internal array and returns read data after the programmed CAS latency.
- Flags protocol and timing violations through sticky error outputs.

---
 rtl/sdram_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// Single-chip SDR SDRAM device model: decodes controller commands, tracks one open row per bank,
// stores data in an internal array and returns reads after the programmed CAS latency.
module sdram_responder #(
    parameter int AddrWidth  = 13,
    parameter int DataWidth  = 16,
    parameter int RowBits    = 4,
    parameter int ColBits    = 4,
    parameter int CasLatency = 3,
    parameter int TRcd       = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [AddrWidth-1:0] i_dram_addr,
    input  logic [DataWidth-1:0] i_dram_dq,
    output logic [DataWidth-1:0] o_dram_dq,
    output logic                 o_dram_dq_oe,
    input  logic                 i_dram_ba_0,
    input  logic                 i_dram_ba_1,
    input  logic                 i_dram_ldqm,
    input  logic                 i_dram_udqm,
    input  logic                 i_dram_we_n,
    input  logic                 i_dram_cas_n,
    input  logic                 i_dram_ras_n,
    input  logic                 i_dram_cs_n,
    input  logic                 i_dram_cke,
    output logic                 o_ready,
    output logic                 o_err,
    output logic [2:0]           o_err_code
);

    localparam int IdxBits = 2 + RowBits + ColBits;
    localparam int Depth   = 1 << IdxBits;
    localparam int RcdW    = (TRcd > 1) ? $clog2(TRcd) : 1;
    localparam logic [RcdW-1:0] RcdLoad = RcdW'(TRcd - 1);

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_READ,
        CMD_WRITE,
        CMD_PRE,
        CMD_REF,
        CMD_LMR
    } cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_PRE,
        ST_WAIT_REF,
        ST_WAIT_LMR,
        ST_READY
    } init_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_INIT      = 3'd1,
        ERR_CLOSED    = 3'd2,
        ERR_ACT_OPEN  = 3'd3,
        ERR_TRCD      = 3'd4,
        ERR_BANK_OPEN = 3'd5,
        ERR_MODE      = 3'd6,
        ERR_RD_WR     = 3'd7
    } err_e;

    init_e                           state_q, state_d;
    logic                            ref_cnt_q, ref_cnt_d;
    logic [1:0]                      cl_q, cl_d;
    logic [3:0]                      open_q, open_d;
    logic [3:0][RowBits-1:0]         row_q, row_d;
    logic [3:0][RcdW-1:0]            rcd_q, rcd_d;
    logic [2:0]                      pv_q, pv_d;
    logic [2:0][DataWidth-1:0]       pd_q, pd_d;
    logic [DataWidth-1:0]            dq_q, dq_d;
    logic                            oe_q, oe_d;
    logic                            err_q, err_d;
    err_e                            code_q, code_d;

    logic [DataWidth-1:0]            mem_q [Depth];
    cmd_e                            cmd;
    err_e                            viol;
    logic                            mem_we;
    logic [1:0]                      ba;
    logic                            a10;
    logic                            mode_cl_ok;
    logic [IdxBits-1:0]              mem_idx;
    logic [DataWidth-1:0]            rd_word;
    logic [DataWidth-1:0]            rd_data;
    logic                            addr_unused;

    assign ba         = {i_dram_ba_1, i_dram_ba_0};
    assign a10        = i_dram_addr[10];
    assign mode_cl_ok = (i_dram_addr[6:4] == 3'd2) || (i_dram_addr[6:4] == 3'd3);
    assign mem_idx    = {ba, row_q[ba], i_dram_addr[ColBits-1:0]};
    assign rd_word    = mem_q[mem_idx];
    assign rd_data    = {i_dram_udqm ? 8'h00 : rd_word[15:8], i_dram_ldqm ? 8'h00 : rd_word[7:0]};
    // Address bits above the stored row/column fields carry no state in this model.
    assign addr_unused = ^i_dram_addr;

    always_comb begin
        cmd = CMD_NOP;
        if (i_dram_cke && !i_dram_cs_n) begin
            case ({i_dram_ras_n, i_dram_cas_n, i_dram_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_LMR;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        cl_d      = cl_q;
        open_d    = open_q;
        row_d     = row_q;
        rcd_d     = rcd_q;
        pv_d      = pv_q;
        pd_d      = pd_q;
        dq_d      = dq_q;
        oe_d      = oe_q;
        err_d     = err_q;
        code_d    = code_q;
        viol      = ERR_NONE;
        mem_we    = 1'b0;

        if (i_dram_cke) begin
            for (int b = 0; b < 4; b++) begin
                if (rcd_q[b] != '0) rcd_d[b] = rcd_q[b] - RcdW'(1);
            end
            oe_d = pv_q[0];
            dq_d = pv_q[0] ? pd_q[0] : '0;
            pv_d = {1'b0, pv_q[2:1]};
            pd_d = {{DataWidth{1'b0}}, pd_q[2:1]};

            case (cmd)
                CMD_ACT: begin
                    if (state_q != ST_READY) begin
                        viol = ERR_INIT;
                    end else begin
                        if (open_q[ba]) viol = ERR_ACT_OPEN;
                        open_d[ba] = 1'b1;
                        row_d[ba]  = i_dram_addr[RowBits-1:0];
                        rcd_d[ba]  = RcdLoad;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (state_q != ST_READY) begin
                        viol = ERR_INIT;
                    end else if (!open_q[ba]) begin
                        viol = ERR_CLOSED;
                    end else begin
                        if (rcd_q[ba] != '0)                 viol = ERR_TRCD;
                        else if (cmd == CMD_WRITE && |pv_q)  viol = ERR_RD_WR;
                        if (cmd == CMD_WRITE) begin
                            mem_we = 1'b1;
                            // A write overtaking queued reads kills them, including the one due next cycle.
                            if (|pv_q) begin
                                pv_d = '0;
                                oe_d = 1'b0;
                                dq_d = '0;
                            end
                        end else begin
                            pv_d[cl_q - 2'd1] = 1'b1;
                            pd_d[cl_q - 2'd1] = rd_data;
                        end
                        if (a10) open_d[ba] = 1'b0;
                    end
                end
                CMD_PRE: begin
                    if (a10) open_d     = '0;
                    else     open_d[ba] = 1'b0;
                    if (state_q == ST_WAIT_PRE && a10) state_d = ST_WAIT_REF;
                end
                CMD_REF: begin
                    if (|open_q) viol = ERR_BANK_OPEN;
                    if (state_q == ST_WAIT_REF) begin
                        if (ref_cnt_q) state_d = ST_WAIT_LMR;
                        ref_cnt_d = ~ref_cnt_q;
                    end
                end
                CMD_LMR: begin
                    if (|open_q)                                  viol = ERR_BANK_OPEN;
                    else if (!mode_cl_ok || i_dram_addr[2:0] != 3'b000) viol = ERR_MODE;
                    if (mode_cl_ok) cl_d = i_dram_addr[5:4];
                    if (state_q == ST_WAIT_LMR) state_d = ST_READY;
                end
                default: ;
            endcase

            if (!err_q && viol != ERR_NONE) begin
                err_d  = 1'b1;
                code_d = viol;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_WAIT_PRE;
            ref_cnt_q <= 1'b0;
            cl_q      <= 2'(CasLatency);
            open_q    <= '0;
            row_q     <= '0;
            rcd_q     <= '0;
            pv_q      <= '0;
            pd_q      <= '0;
            dq_q      <= '0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            cl_q      <= cl_d;
            open_q    <= open_d;
            row_q     <= row_d;
            rcd_q     <= rcd_d;
            pv_q      <= pv_d;
            pd_q      <= pd_d;
            dq_q      <= dq_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    // NOTE: the array has no reset; real DRAM powers up with undefined contents and this keeps it RAM-mappable.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            if (!i_dram_ldqm) mem_q[mem_idx][7:0]  <= i_dram_dq[7:0];
            if (!i_dram_udqm) mem_q[mem_idx][15:8] <= i_dram_dq[15:8];
        end
    end

    assign o_dram_dq    = dq_q;
    assign o_dram_dq_oe = oe_q;
    assign o_ready      = (state_q == ST_READY);
    assign o_err        = err_q;
    assign o_err_code   = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: the driver queues expected read beats with their due
// cycle; an independent negedge monitor pops and checks whenever the model drives data.
module tb_sdram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        oe, ba0, ba1, ldqm, udqm, we_n, cas_n, ras_n, cs_n, cke;
    logic        ready, err;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    sdram_responder dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dram_addr  (addr),
        .i_dram_dq    (dq_in),
        .o_dram_dq    (dq_out),
        .o_dram_dq_oe (oe),
        .i_dram_ba_0  (ba0),
        .i_dram_ba_1  (ba1),
        .i_dram_ldqm  (ldqm),
        .i_dram_udqm  (udqm),
        .i_dram_we_n  (we_n),
        .i_dram_cas_n (cas_n),
        .i_dram_ras_n (ras_n),
        .i_dram_cs_n  (cs_n),
        .i_dram_cke   (cke),
        .o_ready      (ready),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("oe_unexpected", 32'(oe), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(dq_out), 32'(e.data));
                check("rd_cycle", cyc, e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("rd_oe_missing", 32'(oe), 32'd1);
        end
    end

    task automatic drive(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic lm, input logic um);
        @(negedge clk);
        cke  = 1'b1;
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rcw;
        {ba1, ba0} = ba;
        addr  = a;
        dq_in = d;
        ldqm  = lm;
        udqm  = um;
    endtask

    task automatic nop(input int n);
        repeat (n) drive(3'b111, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic act(input logic [1:0] ba, input logic [12:0] row);
        drive(3'b011, ba, row, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] a, input logic lm);
        drive(3'b101, ba, a, 16'h0, lm, 1'b0);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [12:0] a, input logic [15:0] d, input logic um);
        drive(3'b100, ba, a, d, 1'b0, um);
    endtask

    task automatic pre(input logic [1:0] ba, input logic [12:0] a);
        drive(3'b010, ba, a, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic refresh();
        drive(3'b001, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic lmr(input logic [12:0] a);
        drive(3'b000, 2'd0, a, 16'h0, 1'b0, 1'b0);
    endtask

    // Call in the same slot as the READ drive; lat counts edges after the READ edge.
    task automatic expect_rd(input logic [15:0] d, input int lat);
        exp_q.push_back('{due: cyc + 1 + lat, data: d});
    endtask

    task automatic do_init(input logic [12:0] mode);
        pre(2'd0, 13'h400);
        refresh();
        refresh();
        lmr(mode);
        check("ready_before_lmr", 32'(ready), 32'd0);
        nop(1);
        check("ready_after_lmr", 32'(ready), 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        cke   = 1'b1;
        cs_n  = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        we_n  = 1'b1;
        ba0   = 1'b0;
        ba1   = 1'b0;
        addr  = '0;
        dq_in = '0;
        ldqm  = 1'b0;
        udqm  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_dq", 32'(dq_out), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;

        do_init(13'h030);
        check("init_err", 32'(err), 32'd0);

        // CL=3 write then read back
        act(2'd1, 13'h5);
        nop(2);
        wr(2'd1, 13'h7, 16'hBEEF, 1'b0);
        rd(2'd1, 13'h7, 1'b0);
        expect_rd(16'hBEEF, 3);
        nop(6);

        // Switch to CL=2 (banks must be closed first)
        pre(2'd0, 13'h400);
        lmr(13'h020);
        act(2'd1, 13'h5);
        nop(2);
        rd(2'd1, 13'h7, 1'b0);
        expect_rd(16'hBEEF, 2);
        nop(4);
        check("cl2_err", 32'(err), 32'd0);

        // Byte masks
        wr(2'd1, 13'h7, 16'h1234, 1'b1);
        rd(2'd1, 13'h7, 1'b0);
        expect_rd(16'hBE34, 2);
        rd(2'd1, 13'h7, 1'b1);
        expect_rd(16'hBE00, 2);
        nop(4);

        // All four banks, back-to-back reads
        act(2'd0, 13'h1);
        act(2'd2, 13'h2);
        act(2'd3, 13'h3);
        nop(2);
        wr(2'd0, 13'h1, 16'h1111, 1'b0);
        wr(2'd1, 13'h2, 16'h2222, 1'b0);
        wr(2'd2, 13'h3, 16'h3333, 1'b0);
        wr(2'd3, 13'h4, 16'h4444, 1'b0);
        rd(2'd0, 13'h1, 1'b0);
        expect_rd(16'h1111, 2);
        rd(2'd1, 13'h2, 1'b0);
        expect_rd(16'h2222, 2);
        rd(2'd2, 13'h3, 1'b0);
        expect_rd(16'h3333, 2);
        rd(2'd3, 13'h4, 1'b0);
        expect_rd(16'h4444, 2);
        nop(4);
        check("banks_err", 32'(err), 32'd0);
        check("banks_code", 32'(err_code), 32'd0);

        // Auto-precharge read, then a read to the now-closed bank
        rd(2'd3, 13'h404, 1'b0);
        expect_rd(16'h4444, 2);
        nop(4);
        rd(2'd3, 13'h4, 1'b0);
        nop(4);
        check("closed_err", 32'(err), 32'd1);
        check("closed_code", 32'(err_code), 32'd2);

        // tRCD violation after the first error: code sticks, access still executes
        act(2'd3, 13'h3);
        rd(2'd3, 13'h4, 1'b0);
        expect_rd(16'h4444, 2);
        nop(4);
        check("sticky_code", 32'(err_code), 32'd2);

        // Write overtaking a queued read cancels it
        rd(2'd0, 13'h1, 1'b0);
        wr(2'd0, 13'h1, 16'h5555, 1'b0);
        nop(4);
        rd(2'd0, 13'h1, 1'b0);
        expect_rd(16'h5555, 2);
        nop(4);

        // Two frozen cycles (READ left on the pins must be ignored)
        rd(2'd1, 13'h2, 1'b0);
        expect_rd(16'h2222, 4);
        repeat (2) begin
            @(negedge clk);
            cke = 1'b0;
        end
        nop(5);

        // Reset in the middle of a read
        rd(2'd1, 13'h2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        @(negedge clk);
        check("midrst_oe", 32'(oe), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        check("midrst_oe_late", 32'(oe), 32'd0);
        rst_n = 1'b1;

        // Fresh run: READ one cycle after ACTIVE
        do_init(13'h030);
        act(2'd2, 13'h2);
        rd(2'd2, 13'h3, 1'b0);
        expect_rd(16'h3333, 3);
        nop(6);
        check("trcd_err", 32'(err), 32'd1);
        check("trcd_code", 32'(err_code), 32'd4);

        nop(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
